fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Consumer side of the `pc` address stream. Reads the current PC, issues one instruction-memory read per PC value and captures the response.
- Presents each fetched instruction, with its PC, to decode over a valid/ready handshake.
- Drives `pc` enable/mode itself: increment after each accepted response, or jump on a redirect from execute. `jmp_addr` is wired directly from execute to `pc`.
- At most one outstanding memory request; one-entry output register.

Parameters:
- none. Word width is the `word` type (32 bit); PC step is `INSTRUCTION_SIZE_IN_BYTES`, applied inside `pc`.

Ports:
- clk  in  1  clock, all state on rising edge
- res_n  in  1  asynchronous active-low reset
- pc_in  in  32  current PC from `pc`
- pc_enable  out  1  enable to `pc`
- pc_mode  out  1  `PC_MODE_INCREMENT` / `PC_MODE_JUMP` to `pc`
- redirect  in  1  single-cycle pulse from execute: `pc` must load `jmp_addr`
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  request address
- mem_rsp_valid  in  1  read data valid; at most one response per accepted request, at least 1 cycle after accept
- mem_rsp_data  in  32  read data
- instr_valid  out  1  instruction available to decode
- instr_ready  in  1  decode accepts instruction
- instr  out  32  fetched instruction word
- instr_pc  out  32  address `instr` was fetched from

Behaviour:
- FSM states: IDLE, REQ, WAIT, HOLD. Flag: `discard`.
- Reset (res_n low, async):
  - state=IDLE, `discard`=0, instr=0, instr_pc=0.
  - All control outputs 0 while in reset.
- IDLE: all control outputs 0; → REQ next cycle. If redirect: pc_enable=1, pc_mode=JUMP, → REQ.
- REQ:
  - mem_req_valid=1, mem_req_addr=pc_in.
  - On mem_req_valid&&mem_req_ready → WAIT.
  - mem_req_addr must remain stable while valid and not ready; `pc` is only enabled by this block, so pc_in holds.
- WAIT: on mem_rsp_valid and `discard`=0:
  - Register instr=mem_rsp_data, instr_pc=pc_in.
  - pc_enable=1, pc_mode=INCREMENT in the same cycle.
  - → HOLD. pc_in shows instr_pc+4 on the next cycle.
- WAIT: on mem_rsp_valid and `discard`=1: drop data, no pc_enable, clear `discard`, → REQ.
- HOLD: instr_valid=1; on instr_ready → REQ. instr and instr_pc are stable while in HOLD.
- Redirect has priority over everything in the cycle it is high:
  - pc_enable=1, pc_mode=JUMP.
  - mem_req_valid forced 0; instr_valid forced 0. A combinational gate on redirect is allowed.
  - REQ or HOLD: → REQ. The held instruction is lost; an instr_ready in the same cycle is ignored.
  - WAIT without a response that cycle: set `discard`, stay WAIT; the later response is dropped.
  - WAIT with mem_rsp_valid in the same cycle: drop data, no increment, → REQ.
- Never pc_enable with INCREMENT and JUMP in the same cycle; pc_enable=0 in all other cases.
- Response while not in WAIT: protocol violation, ignored.
- Reset mid-operation: in-flight memory response after reset release is the memory's responsibility. Memory must be reset together with this block.
- Throughput: one instruction per 3 cycles minimum (REQ, WAIT, HOLD), with zero-wait memory and decode always ready.

Test Plan:
- Setup: bench instantiates `pc` with INIT_ADDR=32'h0000_0000; memory ready=1, 1-cycle response latency, data = addr^32'hA5A5_0000.
- Reset, then free run, instr_ready=1 → instr_pc sequence 0x0,0x4,0x8 with matching instr; mem_req_valid=0 during reset and for the IDLE cycle.
- Decode backpressure: instr_ready=0 for 5 cycles in HOLD → instr/instr_pc unchanged; no new mem request; pc_in stays instr_pc+4.
- Memory stall: mem_req_ready=0 for 3 cycles → mem_req_addr constant; single request accepted; no pc_enable until response.
- Redirect in WAIT, jmp_addr=0x100, response 2 cycles later → response dropped; next request addr 0x100; first delivered instr_pc=0x100.
- Redirect coincident with mem_rsp_valid, and separately redirect in HOLD with instr_ready=1 → no instruction delivered from old path; pc_mode=JUMP only, never INCREMENT that cycle; next instr_pc=jmp_addr.
- Async reset asserted mid-WAIT → outputs 0 immediately without a clock edge; after release, fetch restarts at 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues one instruction-memory read per PC value, captures the response into
// a one-entry output register and hands it to decode over valid/ready. It also
// steers the external PC register: increment after each accepted response, or
// jump when execute redirects.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | first cycle after reset, nothing issued yet
// REQ   | read request presented at pc_in, waiting for mem_req_ready
// WAIT  | request accepted, waiting for the single response
// HOLD  | instruction captured, presented to decode until accepted
//
// discard marks a response that belongs to a path abandoned by a redirect
// while in WAIT; that response is dropped when it arrives.

module fetch_unit (
    input  logic        clk,
    input  logic        res_n,
    input  logic [31:0] pc_in,
    output logic        pc_enable,
    output logic        pc_mode,
    input  logic        redirect,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam logic PC_MODE_INCREMENT = 1'b0;
    localparam logic PC_MODE_JUMP      = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        discard_q;
    logic        discard_d;
    logic        capture;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;

    // The PC register is only advanced by this block, so pc_in is stable for
    // the whole time a request is pending and can drive the address directly.
    assign mem_req_addr = pc_in;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;

    // State and discard flag registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // Next state and control outputs; a redirect overrides every other action
    // in the cycle it is high and always yields a pure jump.
    always_comb begin
        state_d       = state_q;
        discard_d     = discard_q;
        capture       = 1'b0;
        pc_enable     = 1'b0;
        pc_mode       = PC_MODE_INCREMENT;
        mem_req_valid = 1'b0;
        instr_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) begin
                    pc_enable = 1'b1;
                    pc_mode   = PC_MODE_JUMP;
                end
            end

            REQ: begin
                if (redirect) begin
                    pc_enable = 1'b1;
                    pc_mode   = PC_MODE_JUMP;
                    state_d   = REQ;
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                if (redirect) begin
                    pc_enable = 1'b1;
                    pc_mode   = PC_MODE_JUMP;
                    if (mem_rsp_valid) begin
                        // Response belongs to the old path: drop it now.
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        // Response still in flight: remember to drop it.
                        discard_d = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = REQ;
                    end else begin
                        capture   = 1'b1;
                        pc_enable = 1'b1;
                        pc_mode   = PC_MODE_INCREMENT;
                        state_d   = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_enable = 1'b1;
                    pc_mode   = PC_MODE_JUMP;
                    state_d   = REQ;
                end else begin
                    instr_valid = 1'b1;
                    if (instr_ready) begin
                        state_d = REQ;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
        endcase

        // Keep the PC register untouched while this block is held in reset.
        if (!res_n) begin
            pc_enable     = 1'b0;
            pc_mode       = PC_MODE_INCREMENT;
            mem_req_valid = 1'b0;
            instr_valid   = 1'b0;
        end
    end

    // Output register: instruction word and the PC it was read from. pc_in
    // still holds the request address here because the increment is issued
    // in this same cycle.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else if (capture) begin
            instr_q    <= mem_rsp_data;
            instr_pc_q <= pc_in;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural PC register and instruction memory,
// scoreboard of expected deliveries to decode.

module tb_fetch_unit;

    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        res_n;
    logic [31:0] pc_in;
    logic        pc_enable;
    logic        pc_mode;
    logic        redirect;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic [31:0] jmp_addr;
    logic [31:0] pc_q;

    logic        mem_ready_en;
    int unsigned mem_lat;
    logic        pend;
    int unsigned cnt;
    logic [31:0] paddr;
    int unsigned acc_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .res_n         (res_n),
        .pc_in         (pc_in),
        .pc_enable     (pc_enable),
        .pc_mode       (pc_mode),
        .redirect      (redirect),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    // PC register: reset to 0, step 4, jump loads jmp_addr.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pc_q <= 32'd0;
        end else if (pc_enable) begin
            pc_q <= pc_mode ? jmp_addr : pc_q + 32'd4;
        end
    end
    assign pc_in = pc_q;

    // Memory: one response mem_lat cycles after accept, data = addr ^ key.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            pend    <= 1'b0;
            cnt     <= 0;
            paddr   <= 32'd0;
            acc_cnt <= 0;
        end else if (mem_req_valid && mem_req_ready) begin
            pend    <= 1'b1;
            cnt     <= mem_lat - 1;
            paddr   <= mem_req_addr;
            acc_cnt <= acc_cnt + 1;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end
    assign mem_req_ready = mem_ready_en;
    assign mem_rsp_valid = pend && (cnt == 0);
    assign mem_rsp_data  = paddr ^ DATA_KEY;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.data = a ^ DATA_KEY;
        sb_q.push_back(e);
    endtask

    // Let decode accept until every expected instruction has been delivered.
    task automatic drain(input string tag);
        int n = 0;
        instr_ready = 1'b1;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
        instr_ready = 1'b0;
    endtask

    task automatic wait_ival(input string tag);
        for (int n = 0; n < 30 && !instr_valid; n++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_ival_tmo"}, 32'(instr_valid), 32'd1);
    endtask

    task automatic wait_accept(input string tag);
        int unsigned a0 = acc_cnt;
        for (int n = 0; n < 30 && acc_cnt == a0; n++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_acc_tmo"}, 32'(acc_cnt - a0), 32'd1);
    endtask

    // Decode side monitor plus redirect-cycle checks.
    always @(negedge clk) begin : mon
        exp_t e;
        if (res_n && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_size", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("instr_pc", instr_pc, e.pc);
                chk("instr", instr, e.data);
            end
        end
        if (res_n && redirect) begin
            chk("redir_en", 32'(pc_enable), 32'd1);
            chk("redir_mode", 32'(pc_mode), 32'd1);
            chk("redir_req", 32'(mem_req_valid), 32'd0);
            chk("redir_ival", 32'(instr_valid), 32'd0);
        end
    end

    initial begin
        int unsigned acc0;
        res_n        = 1'b0;
        redirect     = 1'b1;
        jmp_addr     = 32'h0000_0F00;
        instr_ready  = 1'b0;
        mem_ready_en = 1'b1;
        mem_lat      = 1;

        // Reset: all control outputs low even with redirect asserted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req_valid), 32'd0);
        chk("rst_pcen", 32'(pc_enable), 32'd0);
        chk("rst_ival", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_ipc", instr_pc, 32'd0);
        redirect = 1'b0;
        @(posedge clk); #1;
        res_n = 1'b1;
        chk("idle_req", 32'(mem_req_valid), 32'd0);

        // Free run.
        push_exp(32'h0);
        push_exp(32'h4);
        push_exp(32'h8);
        drain("run");

        // Decode backpressure on 0xC.
        wait_ival("bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_ipc", instr_pc, 32'hC);
            chk("bp_instr", instr, 32'hC ^ DATA_KEY);
            chk("bp_req", 32'(mem_req_valid), 32'd0);
            chk("bp_pc", pc_in, 32'h10);
            @(posedge clk); #1;
        end
        push_exp(32'hC);
        mem_ready_en = 1'b0;
        drain("bp");

        // Memory stall on 0x10.
        for (int i = 0; i < 3; i++) begin
            chk("st_req", 32'(mem_req_valid), 32'd1);
            chk("st_addr", mem_req_addr, 32'h10);
            chk("st_pcen", 32'(pc_enable), 32'd0);
            @(posedge clk); #1;
        end
        acc0 = acc_cnt;
        mem_ready_en = 1'b1;
        wait_ival("st");
        chk("st_acc", 32'(acc_cnt - acc0), 32'd1);
        push_exp(32'h10);
        mem_lat = 2;
        drain("st");

        // Redirect in WAIT, response arrives later and must be dropped.
        wait_accept("rdw");
        chk("rdw_rsp", 32'(mem_rsp_valid), 32'd0);
        redirect = 1'b1;
        jmp_addr = 32'h100;
        @(posedge clk); #1;
        redirect = 1'b0;
        mem_lat  = 1;
        for (int n = 0; n < 20 && !mem_req_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("rdw_addr", mem_req_addr, 32'h100);
        push_exp(32'h100);
        drain("rdw");

        // Redirect coincident with the response for 0x104.
        for (int n = 0; n < 20 && !mem_rsp_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("co_rsp", 32'(mem_rsp_valid), 32'd1);
        redirect = 1'b1;
        jmp_addr = 32'h200;
        @(posedge clk); #1;
        redirect = 1'b0;
        chk("co_pc", pc_in, 32'h200);
        push_exp(32'h200);
        drain("co");

        // Redirect in HOLD with decode ready in the same cycle.
        wait_ival("hd");
        redirect    = 1'b1;
        jmp_addr    = 32'h300;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("hd_pc", pc_in, 32'h300);
        push_exp(32'h300);
        drain("hd");

        // Asynchronous reset in the middle of WAIT.
        mem_lat = 2;
        wait_accept("ar");
        #2;
        res_n = 1'b0;
        #1;
        chk("ar_req", 32'(mem_req_valid), 32'd0);
        chk("ar_pcen", 32'(pc_enable), 32'd0);
        chk("ar_ival", 32'(instr_valid), 32'd0);
        chk("ar_instr", instr, 32'd0);
        chk("ar_ipc", instr_pc, 32'd0);
        @(posedge clk); #1;
        res_n   = 1'b1;
        mem_lat = 1;
        push_exp(32'h0);
        push_exp(32'h4);
        drain("ar");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
